// File: rtl/crypt_pkg.sv
// Shared types and constants for the encrypting transmit scheduler.
package crypt_pkg;

  localparam int KEY_W  = 8;
  localparam int DATA_W = 8;

  // Last encoder bit slot: start, data0-7, parity, stop -> 0..10
  localparam logic [3:0] SLOT_LAST = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-bit left rotation used to roll the key between frames
  function automatic logic [KEY_W-1:0] key_roll(input logic [KEY_W-1:0] k);
    return {k[KEY_W-2:0], k[KEY_W-1]};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The pointer remembers who was granted last; on a tie the other side wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic last_gnt;

  // Grant selection: sole requester wins, tie goes to the one not served last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves only when the grant is actually consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (advance && (|gnt)) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/crypt_tx_sched.sv
// Encrypting transmit scheduler: arbitrates two byte requesters and walks the
// encoder through 11 bit slots of BAUD_DIV cycles each, then one DONE cycle.
// Optional build macro CRYPT_KEY_ROLL_EN rotates the key left by one on every
// entry into DONE (a same-cycle key_load wins).
module crypt_tx_sched
  import crypt_pkg::*;
#(
  parameter int               BAUD_DIV  = 16,
  parameter logic [KEY_W-1:0] RESET_KEY = 8'd13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  key_in,
  output logic [DATA_W-1:0] enc_data,
  output logic [KEY_W-1:0]  enc_key,
  output logic              Tx_WR,
  output logic [3:0]        cur_state,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   baud_cnt;
  logic               baud_end;
  logic               accept;
  logic [1:0]         gnt;
  logic [KEY_W-1:0]   key_reg;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign baud_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

  // Next-state decode; accept only from IDLE and never while reset is held
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          accept    = ~reset;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (baud_end && (cur_state == SLOT_LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = accept & gnt[0];
  assign req1_ready = accept & gnt[1];
  assign Tx_WR      = (state == SEND);
  assign busy       = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Baud divider and bit-slot index; both sit at zero outside SEND
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt  <= '0;
      cur_state <= 4'd0;
    end else if (state == SEND) begin
      if (baud_end) begin
        baud_cnt  <= '0;
        cur_state <= (cur_state == SLOT_LAST) ? 4'd0 : cur_state + 4'd1;
      end else begin
        baud_cnt  <= baud_cnt + CNT_W'(1);
      end
    end else begin
      baud_cnt  <= '0;
      cur_state <= 4'd0;
    end
  end

  // Frame payload captured at accept and held until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_data <= '0;
      enc_key  <= RESET_KEY;
      grant_id <= 1'b0;
    end else if (accept) begin
      enc_data <= gnt[1] ? req1_data : req0_data;
      enc_key  <= key_reg;
      grant_id <= gnt[1];
    end
  end

  // Key register; frames in flight use the copy taken at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg <= RESET_KEY;
    end else if (key_load) begin
      key_reg <= key_in;
`ifdef CRYPT_KEY_ROLL_EN
    end else if ((state == SEND) && (state_nxt == DONE)) begin
      key_reg <= key_roll(key_reg);
`endif
    end
  end

endmodule

// File: tb/tb_crypt_tx_sched.sv
// Scoreboard bench for crypt_tx_sched with BAUD_DIV=4: directed scenarios then
// random traffic, checked against a frame-level reference model.
module tb_crypt_tx_sched;

  localparam int         B     = 4;
  localparam int         FRAME = 11 * B;
  localparam logic [7:0] RK    = 8'd13;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, kl = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, ki = 8'h00;
  logic       r0, r1, wr, busy, gid;
  logic [7:0] ed, ek;
  logic [3:0] cs;

  always #5 clk = ~clk;

  crypt_tx_sched #(.BAUD_DIV(B), .RESET_KEY(RK)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (v0),
    .req1_valid (v1),
    .req0_data  (d0),
    .req1_data  (d1),
    .req0_ready (r0),
    .req1_ready (r1),
    .key_load   (kl),
    .key_in     (ki),
    .enc_data   (ed),
    .enc_key    (ek),
    .Tx_WR      (wr),
    .cur_state  (cs),
    .busy       (busy),
    .grant_id   (gid)
  );

  typedef struct {
    int id;
    int data;
    int key;
  } frame_t;

  frame_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a frame occupies the scheduler for 11*B+2 cycles from
  // its accept; winners follow the round-robin rule; key follows load/roll.
  int         cyc     = 0;
  int         m_free  = 0;
  int         roll_at = -1;
  int         m_last  = 1;
  int         m_w     = 0;
  logic [7:0] m_key   = RK;

  always @(negedge clk) begin
    if (reset) begin
      m_key   = RK;
      m_last  = 1;
      m_free  = cyc + 1;
      roll_at = -1;
    end else begin
      if (cyc >= m_free && (v0 || v1)) begin
        m_w = (v0 && v1) ? (1 - m_last) : (v1 ? 1 : 0);
        exp_q.push_back('{m_w, int'(m_w == 1 ? d1 : d0), int'(m_key)});
        m_last  = m_w;
        m_free  = cyc + FRAME + 2;
        roll_at = cyc + FRAME;
      end
      if (kl) begin
        m_key = ki;
      end
`ifdef CRYPT_KEY_ROLL_EN
      else if (cyc == roll_at) begin
        m_key = {m_key[6:0], m_key[7]};
      end
`endif
    end
    cyc++;
  end

  // Monitor: tracks the frame position after each observed accept and checks
  // timing, payload stability and accept pulses against the model queue.
  int     pos      = -1;
  bit     armed    = 1'b0;
  bit     prev_rst = 1'b0;
  frame_t cur      = '{0, 0, 0};
  frame_t e;

  always @(negedge clk) begin
    #1;
    if (prev_rst) begin
      armed = 1'b1;
      pos   = -1;
      cur   = '{0, 0, int'(RK)};
    end else if (pos >= 0) begin
      pos++;
      if (pos > FRAME + 1) pos = -1;
    end
    if (armed) begin
      chk("tx_wr",     int'(wr),   (pos >= 1 && pos <= FRAME) ? 1 : 0);
      chk("cur_state", int'(cs),   (pos >= 1 && pos <= FRAME) ? (pos - 1) / B : 0);
      chk("busy",      int'(busy), (pos >= 1) ? 1 : 0);
      chk("enc_data",  int'(ed),   cur.data);
      chk("enc_key",   int'(ek),   cur.key);
      chk("grant_id",  int'(gid),  cur.id);
      if (r0 || r1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ready", int'({r1, r0}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ready_sel", int'({r1, r0}), (e.id == 1) ? 2 : 1);
          cur = e;
          pos = 0;
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_ready", 0, (e.id == 1) ? 2 : 1);
      end
    end
    prev_rst = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;

    // Single req0 frame with data 01 under the reset key
    v0 = 1'b1; d0 = 8'h01;
    step();
    v0 = 1'b0;
    repeat (FRAME + 4) step();

    // Both requesters continuously valid, from a fresh reset
    reset = 1'b1; step(); reset = 1'b0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'hA5; d1 = 8'h3C;
    repeat (4 * (FRAME + 2) + 2) step();
    v0 = 1'b0; v1 = 1'b0;
    repeat (FRAME + 4) step();

    // key_load mid-frame affects only the following frame
    v0 = 1'b1; d0 = 8'h77;
    step();
    v0 = 1'b0;
    repeat (10) step();
    kl = 1'b1; ki = 8'h5A;
    step();
    kl = 1'b0;
    repeat (FRAME) step();
    v0 = 1'b1; d0 = 8'h66;
    step();
    v0 = 1'b0;
    repeat (FRAME + 4) step();

    // Reset at cur_state 5 with req0 still pending
    v0 = 1'b1; d0 = 8'h11;
    step();
    repeat (21) step();
    reset = 1'b1; step(); reset = 1'b0;
    step();
    v0 = 1'b0;
    repeat (FRAME + 4) step();

    // Key 81 over two consecutive frames (rolls only with the macro)
    kl = 1'b1; ki = 8'h81;
    step();
    kl = 1'b0;
    v0 = 1'b1; d0 = 8'h22;
    repeat (2 * (FRAME + 2)) step();
    v0 = 1'b0;
    repeat (FRAME + 4) step();

    // req1 valid for a single cycle only
    v1 = 1'b1; d1 = 8'h42;
    step();
    v1 = 1'b0;
    repeat (FRAME + 10) step();

    // Random traffic, occasional key loads and resets
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      v0    = ($urandom_range(0, 3) != 0);
      v1    = ($urandom_range(0, 2) != 0);
      d0    = 8'($urandom);
      d1    = 8'($urandom);
      kl    = ($urandom_range(0, 39) == 0);
      ki    = 8'($urandom);
      step();
    end
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0; kl = 1'b0;
    repeat (FRAME + 4) step();

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crypt_tx_sched.md
CRYPT_TX_SCHED -- requirements
Module: crypt_tx_sched

Interface
REQ-001 Parameter BAUD_DIV, default 16: clock cycles each cur_state value is held; the block SHALL support BAUD_DIV >= 2.
REQ-002 Parameter RESET_KEY, default 8'd13: value the key register SHALL hold after reset.
REQ-003 Port clk, input, 1: the single clock; every register SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Ports req0_valid, req1_valid, input, 1 each: requester N has a byte to send.
REQ-006 Ports req0_data, req1_data, input, 8 each: plaintext byte of requester N.
REQ-007 Ports req0_ready, req1_ready, output, 1 each: single-cycle accept pulse to requester N.
REQ-008 Port key_load, input, 1: load key_in into the key register.
REQ-009 Port key_in, input, 8: new encryption key.
REQ-010 Port enc_data, output, 8: byte presented to the encoder data input.
REQ-011 Port enc_key, output, 8: key presented to the encoder.
REQ-012 Port Tx_WR, output, 1: encoder write enable, high for the whole frame.
REQ-013 Port cur_state, output, 4: encoder bit-slot index 0..10 (start, data0-7, parity, stop).
REQ-014 Port busy, output, 1: high in SEND and DONE.
REQ-015 Port grant_id, output, 1: requester index of the current or last frame.

Function
REQ-016 States SHALL be exactly IDLE, SEND and DONE.
REQ-017 IDLE with any valid: same cycle, assert winner's ready and latch its data into enc_data; latch key register into enc_key; set grant_id; next cycle SEND, cur_state=0, Tx_WR=1.
REQ-018 Arbitration SHALL be round-robin: sole valid wins; both valid, the requester not granted last wins; ready SHALL never go to both at once.
REQ-019 SEND: hold each cur_state value exactly BAUD_DIV cycles, then increment by 1.
REQ-020 After cur_state 10 has been held BAUD_DIV cycles, go to DONE: Tx_WR=0, cur_state=0.
REQ-021 DONE SHALL last exactly 1 cycle, then go to IDLE, with no accept in DONE.
REQ-022 The frame SHALL be Tx_WR high for 11*BAUD_DIV cycles, and accept-to-accept SHALL be at least 11*BAUD_DIV+2 cycles.
REQ-023 enc_data, enc_key and grant_id SHALL stay stable from accept until the next accept.
REQ-024 key_load SHALL update the key register in any state; a change during SEND SHALL affect only later frames.
REQ-025 Valid dropping or data changing during SEND SHALL have no effect on the frame in flight.
REQ-026 The baud counter SHALL be $clog2(BAUD_DIV) bits wide and wrap to 0 at BAUD_DIV-1.

Reset
REQ-027 Reset SHALL force: state IDLE, Tx_WR=0, cur_state=0, busy=0, both ready=0, enc_data=0, enc_key=RESET_KEY, key register=RESET_KEY, grant_id=0, last-grant pointer=1 (req0 wins first tie), baud counter=0.
REQ-028 Reset mid-frame SHALL abort the frame, with outputs at reset values the next cycle and no ready pulse.

Configuration
REQ-029 With CRYPT_KEY_ROLL_EN defined, on entering DONE the key register SHALL become {key[6:0],key[7]}; a key_load in the same cycle SHALL take priority.
REQ-030 Without CRYPT_KEY_ROLL_EN, the key register SHALL change only on reset or key_load.

Structure
REQ-031 Package crypt_pkg SHALL hold the state enum, SLOT_LAST=4'd10, KEY_W=8 and DATA_W=8.
REQ-032 The round-robin logic SHALL be sub-module rr_arb2 (two requests, pointer register, one-hot grant, advance input).

Verification (BAUD_DIV=4)
REQ-033 Reset, then req0_valid with data 8'h01 -> req0_ready 1 cycle; Tx_WR high 44 cycles; cur_state 0..10, each 4 cycles; enc_data=8'h01, enc_key=8'd13.
REQ-034 Both valid continuously, data 8'hA5 and 8'h3C -> grants alternate 0,1,0,1; enc_data alternates A5,3C; accepts are 46 cycles apart.
REQ-035 key_load with 8'h5A during a frame -> current frame keeps 8'd13; next frame enc_key=8'h5A.
REQ-036 Reset asserted at cur_state 5 -> next cycle Tx_WR=0, cur_state=0, busy=0; after release, pending req0 is accepted.
REQ-037 With CRYPT_KEY_ROLL_EN defined, key 8'h81 over two frames -> enc_key 81, then 03; without the macro -> 81, then 81.
REQ-038 req1 valid 1 cycle then dropped during SEND -> no second frame; req1_ready pulses only once.
